mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-ported RAM between instruction fetch (IF) and data load/store (D).
//   Registers each granted request onto the RAM bus and holds it until mem_ack.
//   Returns read data to the owning requester and drives ram_ready to the pipeline hold FSM.
//   D has priority; a streak limit bounds fetch starvation.
//   Fetch results can be discarded on a pipeline flush.
// PARAMETERS
//   ADDR_W      32  address width, both requesters and RAM bus
//   DATA_W      32  data width; byte enables are DATA_W/8 bits
//   STARVE_MAX  4   consecutive D grants allowed while if_req is pending; 1..15
// PORTS
//   clk        in   1         clock, all state on rising edge
//   reset      in   1         synchronous, active-high
//   flush      in   1         discard in-flight or pending fetch result
//   if_req     in   1         fetch request; held until if_valid or flush
//   if_addr    in   ADDR_W    fetch address
//   if_rdata   out  DATA_W    fetch data; valid with if_valid
//   if_valid   out  1         1-cycle pulse, fetch complete
//   d_req      in   1         data request; held until d_valid
//   d_we       in   1         1 = store, 0 = load
//   d_be       in   DATA_W/8  store byte enables
//   d_addr     in   ADDR_W    data address
//   d_wdata    in   DATA_W    store data
//   d_rdata    out  DATA_W    load data; valid with d_valid
//   d_valid    out  1         1-cycle pulse, load/store complete
//   mem_req    out  1         RAM bus request, registered
//   mem_we     out  1         registered write enable
//   mem_be     out  DATA_W/8  registered byte enables; all-ones on reads
//   mem_addr   out  ADDR_W    registered address
//   mem_wdata  out  DATA_W    registered write data
//   mem_ack    in   1         RAM completes the request this cycle; mem_rdata valid
//   mem_rdata  in   DATA_W    RAM read data
//   ram_ready  out  1         0 while any request is outstanding (combinational)
// BEHAVIOUR
//   Reset:
//     - state IDLE; streak=0; flush_pend=0
//     - mem_req, mem_we, if_valid, d_valid = 0
//     - mem_be, mem_addr, mem_wdata, if_rdata, d_rdata = 0
//     - Reset mid-transaction abandons it: no valid pulse; a later mem_ack in IDLE is ignored.
//   States: IDLE, GRANT_IF, GRANT_D.
//   IDLE:
//     - Samples requests at the clock edge.
//     - d_req, and not (if_req & streak==STARVE_MAX): GRANT_D. Latch d_* to mem_*; mem_req<=1.
//     - else if_req & ~flush: GRANT_IF. Latch if_addr; mem_we=0; mem_be all-ones; mem_req<=1.
//     - On the cycle after a valid pulse, IDLE ignores that requester's still-high req.
//       This gives single-issue per handshake.
//   GRANT_x:
//     - mem_* fields stay stable until mem_ack.
//     - Edge with mem_ack=1: mem_req<=0; state<=IDLE; x_valid<=1 for exactly one cycle.
//       x_rdata<=mem_rdata on loads/fetches; x_rdata is unchanged on stores.
//     - Grant-to-valid latency = 1 + RAM wait cycles. Zero-wait RAM: req edge -> valid 2 cycles later.
//     - Back-to-back issue: earliest new mem_req is 1 cycle after ack (IDLE bubble).
//   Streak counter:
//     - D grant while if_req=1: streak+1, saturating at STARVE_MAX.
//     - Any IF grant, or if_req=0 at a D grant: streak=0.
//   Flush:
//     - flush=1 during GRANT_IF sets flush_pend; the bus transaction still completes.
//     - At that ack, if_valid is suppressed and if_rdata is unchanged; flush_pend clears at ack.
//     - flush=1 in IDLE blocks an IF grant that cycle. It has no effect on D transactions.
//     - flush coinciding with the ack edge also suppresses if_valid.
//   ram_ready = ~((if_req & ~if_valid & ~flush) | (d_req & ~d_valid)).
//     - Simultaneous req and valid counts as ready.
//   mem_ack while IDLE: ignored, no state change.
// TESTING
//   - Zero-wait read: d_req, d_we=0, addr 0x40; RAM acks 1st cycle with 0xDEADBEEF -> d_valid 2 cycles after req, d_rdata=0xDEADBEEF.
//   - Simultaneous if_req and d_req, STARVE_MAX=4, D re-requesting continuously -> 4 D grants, 5th grant IF, streak back to 0.
//   - Store, d_be=4'b0011, RAM waits 3 cycles -> mem_* stable 4 cycles; mem_we=1, mem_be=0011; ram_ready=0 until d_valid.
//   - flush 1 cycle into a 2-wait fetch -> mem_req completes, no if_valid, if_rdata unchanged; next IF grant works normally.
//   - reset asserted in GRANT_D before ack -> next cycle mem_req=0, no d_valid, late mem_ack ignored.
//   - Idle bus with stray mem_ack -> no state change, no valid pulses, ram_ready=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch and data load/store.
// Data has priority; a streak counter caps how long a pending fetch can be starved.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_ready
);

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_D
  } state_t;

  state_t     state;
  logic [3:0] streak;
  logic       flush_pend;
  logic       if_starved;
  logic       d_pick;

  // Priority is decided on the raw requests; a requester whose valid pulse is
  // still high has its req masked, so its branch idles instead of yielding.
  always_comb begin
    if_starved = if_req & (streak == STREAK_MAX);
    d_pick     = d_req & ~if_starved;
  end

  assign ram_ready = ~((if_req & ~if_valid & ~flush) | (d_req & ~d_valid));

  // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      streak     <= '0;
      flush_pend <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_pick) begin
            if (!d_valid) begin
              state     <= GRANT_D;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_be    <= d_we ? d_be : '1;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!if_req) begin
                streak <= '0;
              end else if (streak != STREAK_MAX) begin
                streak <= streak + 4'd1;
              end
            end
          end else if (if_req && !flush && !if_valid) begin
            state      <= GRANT_IF;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= '1;
            mem_addr   <= if_addr;
            streak     <= '0;
            flush_pend <= 1'b0;
          end
        end

        GRANT_IF: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            flush_pend <= 1'b0;
            // A flush seen at any point during the fetch drops its result.
            if (!flush && !flush_pend) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end

        GRANT_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_valid <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a wait-programmable RAM model, per-port
// expected-data queues popped on valid pulses, and a log of bus grants.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata = '0;
  logic          ram_ready;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_ready(ram_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // RAM model: acks after ram_wait idle cycles of a held mem_req.
  int ram_wait  = 0;
  int wcnt      = 0;
  bit ram_ack   = 1'b0;
  bit stray_ack = 1'b0;
  assign mem_ack = ram_ack | stray_ack;

  always @(negedge clk) begin
    ram_ack = 1'b0;
    if (mem_req) begin
      if (wcnt >= ram_wait) begin
        ram_ack   = 1'b1;
        mem_rdata = rd(mem_addr);
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] grants[$];
  logic [31:0] model_d  = '0;
  logic [31:0] model_if = '0;
  bit          last_req = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      last_req = 1'b0;
    end else begin
      if (mem_req && !last_req) grants.push_back(mem_addr);
      last_req = mem_req;
      if (d_valid) begin
        if (d_q.size() == 0) check("d_valid_unexpected", 1, 0);
        else check("d_rdata", d_rdata, d_q.pop_front());
      end
      if (if_valid) begin
        if (if_q.size() == 0) check("if_valid_unexpected", 1, 0);
        else check("if_rdata", if_rdata, if_q.pop_front());
      end
    end
  end

  task automatic d_issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (!we) model_d = rd(addr);
    d_q.push_back(model_d);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
  endtask

  task automatic if_issue(input logic [31:0] addr);
    model_if = rd(addr);
    if_q.push_back(model_if);
    if_req = 1'b1; if_addr = addr;
  endtask

  task automatic wait_valid(input bit is_d, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 50) begin
      @(negedge clk);
      cycles++;
      seen = is_d ? d_valid : if_valid;
    end
    if (!seen) check(is_d ? "d_timeout" : "if_timeout", 0, 1);
  endtask

  // Fetch pending while D streams six loads: four D grants, then IF, then D.
  task automatic starve_round(input logic [31:0] base);
    int          g0;
    int          c_if;
    int          c_d;
    logic [31:0] exp_g[7];
    g0 = grants.size();
    ram_wait = 0;
    for (int i = 0; i < 4; i++) exp_g[i] = base + 32'h2000 + 32'(4 * i);
    exp_g[4] = base + 32'h1000;
    exp_g[5] = base + 32'h2010;
    exp_g[6] = base + 32'h2014;
    fork
      begin
        if_issue(base + 32'h1000);
        wait_valid(1'b0, c_if);
        if_req = 1'b0;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          d_issue(1'b0, 4'hF, base + 32'h2000 + 32'(4 * i), '0);
          wait_valid(1'b1, c_d);
        end
        d_req = 1'b0;
      end
    join
    @(negedge clk);
    check("starve_grant_count", grants.size() - g0, 7);
    if (grants.size() - g0 == 7) begin
      for (int i = 0; i < 7; i++) check($sformatf("starve_grant%0d", i), grants[g0 + i], exp_g[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  req_cycles;
    bit  got_valid;
    bit  saw_ack;
    reset = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_valids", {if_valid, d_valid}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_ram_ready", ram_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait load; d_req held one cycle past d_valid must not re-issue.
    ram_wait = 0;
    d_issue(1'b0, 4'hF, 32'h40, '0);
    #1 check("zw_ram_ready_busy", ram_ready, 0);
    wait_valid(1'b1, cyc);
    check("zw_latency", cyc, 2);
    check("zw_rdata", d_rdata, 32'hDEAD_BEEF);
    check("zw_ready_on_valid", ram_ready, 1);
    @(negedge clk);
    check("zw_single_issue", mem_req, 0);
    check("zw_pulse_width", d_valid, 0);
    d_req = 1'b0;
    @(negedge clk);

    // Store with three RAM wait cycles.
    ram_wait = 3;
    d_issue(1'b1, 4'b0011, 32'h80, 32'hCAFE_1234);
    req_cycles = 0;
    got_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_valid) begin
        got_valid = 1'b1;
        break;
      end
      check("st_ram_ready", ram_ready, 0);
      if (mem_req) begin
        req_cycles++;
        check("st_fields", {mem_we, mem_be, mem_addr, mem_wdata} == {1'b1, 4'b0011, 32'h80, 32'hCAFE_1234}, 1);
      end
    end
    check("st_valid_seen", got_valid, 1);
    check("st_req_cycles", req_cycles, 4);
    check("st_rdata_kept", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    @(negedge clk);

    starve_round(32'h0001_0000);
    starve_round(32'h0002_0000);

    // Flush one cycle into a two-wait fetch.
    ram_wait = 2;
    if_req = 1'b1; if_addr = 32'h3000;
    @(negedge clk);
    check("fl_bus_fields", {mem_req, mem_we, mem_be, mem_addr} == {1'b1, 1'b0, 4'hF, 32'h3000}, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; if_req = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      saw_ack |= mem_ack;
      check("fl_no_valid", if_valid, 0);
    end
    check("fl_bus_acked", saw_ack, 1);
    check("fl_bus_done", mem_req, 0);
    check("fl_rdata_kept", if_rdata, model_if);
    if_issue(32'h3004);
    wait_valid(1'b0, cyc);
    check("fl_next_latency", cyc, 4);
    if_req = 1'b0;
    @(negedge clk);

    // Flush arriving on the ack edge.
    ram_wait = 1;
    if_req = 1'b1; if_addr = 32'h3100;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; if_req = 1'b0;
    check("flc_no_valid", if_valid, 0);
    check("flc_bus_done", mem_req, 0);
    check("flc_rdata_kept", if_rdata, model_if);
    @(negedge clk);

    // Reset during a D transaction, then a stray ack on the idle bus.
    ram_wait = 5;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500;
    @(negedge clk);
    check("rm_granted", mem_req, 1);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check("rm_mem_req", mem_req, 0);
    check("rm_no_valid", d_valid, 0);
    check("rm_d_rdata", d_rdata, 0);
    model_d = '0; model_if = '0;
    reset = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_idle", {mem_req, if_valid, d_valid}, 0);
      check("stray_ready", ram_ready, 1);
    end
    check("stray_rdata", {if_rdata, d_rdata} == 64'h0, 1);

    ram_wait = 0;
    d_issue(1'b0, 4'hF, 32'h44, '0);
    wait_valid(1'b1, cyc);
    check("post_latency", cyc, 2);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    check("if_q_empty", if_q.size(), 0);
    check("d_q_empty", d_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
